// File: rtl/reg_file_sb.sv
// General-purpose register file: one write port, two registered read ports with
// write-to-read bypass, and a per-register pending (scoreboard) bit.
module reg_file_sb #(
   parameter int unsigned WORD_SIZE = 19,
   parameter int unsigned NUM_REGS  = 4,
   parameter int unsigned ADDR_W    = $clog2(NUM_REGS)
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 WR_EN,
   input  logic [ADDR_W-1:0]    WR_ADDR,
   input  logic [WORD_SIZE-1:0] WR_DATA,
   input  logic                 RDA_EN,
   input  logic [ADDR_W-1:0]    RDA_ADDR,
   output logic [WORD_SIZE-1:0] RDA_DATA,
   output logic                 RDA_PEND,
   input  logic                 RDB_EN,
   input  logic [ADDR_W-1:0]    RDB_ADDR,
   output logic [WORD_SIZE-1:0] RDB_DATA,
   output logic                 RDB_PEND,
   input  logic                 SB_SET,
   input  logic [ADDR_W-1:0]    SB_ADDR,
   output logic                 ADDR_ERR
);

   localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
      return {1'b0, a} < NumRegsW;
   endfunction

   logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
   logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]  pend_q, pend_d;
   logic [WORD_SIZE-1:0] rda_data_q, rda_data_d;
   logic [WORD_SIZE-1:0] rdb_data_q, rdb_data_d;
   logic                 rda_pend_q, rda_pend_d;
   logic                 rdb_pend_q, rdb_pend_d;
   logic                 addr_err_q, addr_err_d;

   logic wr_ok, sb_ok, rda_ok, rdb_ok;

   assign wr_ok  = addr_ok(WR_ADDR);
   assign sb_ok  = addr_ok(SB_ADDR);
   assign rda_ok = addr_ok(RDA_ADDR);
   assign rdb_ok = addr_ok(RDB_ADDR);

   always_comb begin
      regs_d     = regs_q;
      pend_d     = pend_q;
      rda_data_d = rda_data_q;
      rda_pend_d = rda_pend_q;
      rdb_data_d = rdb_data_q;
      rdb_pend_d = rdb_pend_q;
      addr_err_d = 1'b0;

      if (WR_EN) begin
         if (wr_ok) begin
            regs_d[WR_ADDR] = WR_DATA;
            pend_d[WR_ADDR] = 1'b0;
         end else begin
            addr_err_d = 1'b1;
         end
      end

      // Applied after the write so a same-index issue keeps the register pending.
      if (SB_SET) begin
         if (sb_ok) begin
            pend_d[SB_ADDR] = 1'b1;
         end else begin
            addr_err_d = 1'b1;
         end
      end

      // Reads sample the post-update state, which provides the bypass.
      if (RDA_EN) begin
         if (rda_ok) begin
            rda_data_d = regs_d[RDA_ADDR];
            rda_pend_d = pend_d[RDA_ADDR];
         end else begin
            rda_data_d = '0;
            rda_pend_d = 1'b0;
            addr_err_d = 1'b1;
         end
      end

      if (RDB_EN) begin
         if (rdb_ok) begin
            rdb_data_d = regs_d[RDB_ADDR];
            rdb_pend_d = pend_d[RDB_ADDR];
         end else begin
            rdb_data_d = '0;
            rdb_pend_d = 1'b0;
            addr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
         pend_q     <= '0;
         rda_data_q <= '0;
         rda_pend_q <= 1'b0;
         rdb_data_q <= '0;
         rdb_pend_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         pend_q     <= pend_d;
         rda_data_q <= rda_data_d;
         rda_pend_q <= rda_pend_d;
         rdb_data_q <= rdb_data_d;
         rdb_pend_q <= rdb_pend_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign RDA_DATA = rda_data_q;
   assign RDA_PEND = rda_pend_q;
   assign RDB_DATA = rdb_data_q;
   assign RDB_PEND = rdb_pend_q;
   assign ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a 4-entry and a 3-entry instance share one stimulus stream and are
// checked against a behavioural model, a directed vector table and hand-written sequences.
module tb_reg_file_sb;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [18:0] wr_data;
   logic        rda_en, rdb_en, sb_set;
   logic [1:0]  rda_addr, rdb_addr, sb_addr;

   logic [18:0] a4_data, b4_data, a3_data, b3_data;
   logic        a4_pend, b4_pend, a3_pend, b3_pend, err4, err3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.WORD_SIZE(19), .NUM_REGS(4)) u_dut4 (
      .CLK(clk), .RST(rst),
      .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .RDA_EN(rda_en), .RDA_ADDR(rda_addr), .RDA_DATA(a4_data), .RDA_PEND(a4_pend),
      .RDB_EN(rdb_en), .RDB_ADDR(rdb_addr), .RDB_DATA(b4_data), .RDB_PEND(b4_pend),
      .SB_SET(sb_set), .SB_ADDR(sb_addr), .ADDR_ERR(err4)
   );

   reg_file_sb #(.WORD_SIZE(19), .NUM_REGS(3)) u_dut3 (
      .CLK(clk), .RST(rst),
      .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data),
      .RDA_EN(rda_en), .RDA_ADDR(rda_addr), .RDA_DATA(a3_data), .RDA_PEND(a3_pend),
      .RDB_EN(rdb_en), .RDB_ADDR(rdb_addr), .RDB_DATA(b3_data), .RDB_PEND(b3_pend),
      .SB_SET(sb_set), .SB_ADDR(sb_addr), .ADDR_ERR(err3)
   );

   // Reference model: index 0 models NUM_REGS=4, index 1 models NUM_REGS=3.
   logic [18:0] m_reg  [2][4];
   bit          m_pend [2][4];
   logic [18:0] e_ad [2], e_bd [2];
   bit          e_ap [2], e_bp [2], e_err [2];

   function automatic void model_step(int k);
      int n = (k == 0) ? 4 : 3;
      bit err = 1'b0;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_reg[k][i]  = '0;
            m_pend[k][i] = 1'b0;
         end
         e_ad[k] = '0; e_bd[k] = '0; e_ap[k] = 0; e_bp[k] = 0; e_err[k] = 0;
         return;
      end
      if (wr_en) begin
         if (int'(wr_addr) < n) begin
            m_reg[k][wr_addr]  = wr_data;
            m_pend[k][wr_addr] = 1'b0;
         end else err = 1'b1;
      end
      if (sb_set) begin
         if (int'(sb_addr) < n) m_pend[k][sb_addr] = 1'b1;
         else err = 1'b1;
      end
      if (rda_en) begin
         if (int'(rda_addr) < n) begin
            e_ad[k] = m_reg[k][rda_addr];
            e_ap[k] = m_pend[k][rda_addr];
         end else begin
            e_ad[k] = '0; e_ap[k] = 1'b0; err = 1'b1;
         end
      end
      if (rdb_en) begin
         if (int'(rdb_addr) < n) begin
            e_bd[k] = m_reg[k][rdb_addr];
            e_bp[k] = m_pend[k][rdb_addr];
         end else begin
            e_bd[k] = '0; e_bp[k] = 1'b0; err = 1'b1;
         end
      end
      e_err[k] = err;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      check("n4.rda_data", 32'(a4_data), 32'(e_ad[0]));
      check("n4.rda_pend", 32'(a4_pend), 32'(e_ap[0]));
      check("n4.rdb_data", 32'(b4_data), 32'(e_bd[0]));
      check("n4.rdb_pend", 32'(b4_pend), 32'(e_bp[0]));
      check("n4.addr_err", 32'(err4),    32'(e_err[0]));
      check("n3.rda_data", 32'(a3_data), 32'(e_ad[1]));
      check("n3.rda_pend", 32'(a3_pend), 32'(e_ap[1]));
      check("n3.rdb_data", 32'(b3_data), 32'(e_bd[1]));
      check("n3.rdb_pend", 32'(b3_pend), 32'(e_bp[1]));
      check("n3.addr_err", 32'(err3),    32'(e_err[1]));
   endtask

   // One clock: inputs already stable, model follows the edge, outputs checked at negedge.
   task automatic step();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0; rda_en = 0; rda_addr = 0;
      rdb_en = 0; rdb_addr = 0; sb_set = 0; sb_addr = 0;
   endtask

   typedef struct {
      bit          rst;
      bit          we;
      logic [1:0]  wa;
      logic [18:0] wd;
      bit          ae;
      logic [1:0]  aa;
      bit          be;
      logic [1:0]  ba;
      bit          ss;
      logic [1:0]  sa;
      logic [18:0] x_ad;
      bit          x_ap;
      logic [18:0] x_bd;
      bit          x_bp;
   } vec_t;

   vec_t vecs [22];

   initial begin
      //            rst we wa  wd        ae aa be ba ss sa  x_ad      ap x_bd      bp
      vecs[0]  = '{1, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[1]  = '{1, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[2]  = '{0, 0, 0, 19'h0,     1, 0, 1, 1, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[3]  = '{0, 0, 0, 19'h0,     1, 2, 1, 3, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[4]  = '{0, 1, 1, 19'h7FFFF, 0, 0, 0, 0, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[5]  = '{0, 1, 2, 19'h12345, 0, 0, 0, 0, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[6]  = '{0, 1, 3, 19'h00001, 0, 0, 0, 0, 0, 0, 19'h0,     0, 19'h0,     0};
      vecs[7]  = '{0, 0, 0, 19'h0,     1, 2, 1, 3, 0, 0, 19'h12345, 0, 19'h00001, 0};
      vecs[8]  = '{0, 0, 0, 19'h0,     0, 0, 0, 0, 0, 0, 19'h12345, 0, 19'h00001, 0};
      vecs[9]  = '{0, 0, 0, 19'h0,     0, 1, 0, 0, 0, 0, 19'h12345, 0, 19'h00001, 0};
      vecs[10] = '{0, 0, 0, 19'h0,     0, 3, 0, 0, 0, 0, 19'h12345, 0, 19'h00001, 0};
      vecs[11] = '{0, 1, 2, 19'h55555, 1, 2, 0, 0, 0, 0, 19'h55555, 0, 19'h00001, 0};
      vecs[12] = '{0, 0, 0, 19'h0,     0, 0, 0, 0, 1, 3, 19'h55555, 0, 19'h00001, 0};
      vecs[13] = '{0, 0, 0, 19'h0,     1, 3, 0, 0, 0, 0, 19'h00001, 1, 19'h00001, 0};
      vecs[14] = '{0, 1, 3, 19'h00AAA, 0, 0, 0, 0, 0, 0, 19'h00001, 1, 19'h00001, 0};
      vecs[15] = '{0, 0, 0, 19'h0,     1, 3, 0, 0, 0, 0, 19'h00AAA, 0, 19'h00001, 0};
      vecs[16] = '{0, 1, 3, 19'h00BBB, 1, 3, 1, 3, 1, 3, 19'h00BBB, 1, 19'h00BBB, 1};
      vecs[17] = '{0, 0, 0, 19'h0,     1, 3, 1, 1, 0, 0, 19'h00BBB, 1, 19'h7FFFF, 0};
      vecs[18] = '{0, 0, 0, 19'h0,     0, 0, 0, 0, 1, 1, 19'h00BBB, 1, 19'h7FFFF, 0};
      vecs[19] = '{0, 0, 0, 19'h0,     1, 1, 0, 0, 0, 0, 19'h7FFFF, 1, 19'h7FFFF, 0};
      vecs[20] = '{1, 1, 1, 19'h00123, 1, 1, 1, 1, 1, 1, 19'h0,     0, 19'h0,     0};
      vecs[21] = '{0, 0, 0, 19'h0,     1, 1, 1, 1, 0, 0, 19'h0,     0, 19'h0,     0};
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) begin
            m_reg[k][i] = '0;
            m_pend[k][i] = 1'b0;
         end
         e_ad[k] = '0; e_bd[k] = '0; e_ap[k] = 0; e_bp[k] = 0; e_err[k] = 0;
      end
      idle();
      #1;

      // Directed test-plan vectors, checked against both the table and the model.
      for (int v = 0; v < 22; v++) begin
         rst = vecs[v].rst;   wr_en = vecs[v].we; wr_addr = vecs[v].wa; wr_data = vecs[v].wd;
         rda_en = vecs[v].ae; rda_addr = vecs[v].aa;
         rdb_en = vecs[v].be; rdb_addr = vecs[v].ba;
         sb_set = vecs[v].ss; sb_addr = vecs[v].sa;
         step();
         check($sformatf("vec%0d.rda_data", v), 32'(a4_data), 32'(vecs[v].x_ad));
         check($sformatf("vec%0d.rda_pend", v), 32'(a4_pend), 32'(vecs[v].x_ap));
         check($sformatf("vec%0d.rdb_data", v), 32'(b4_data), 32'(vecs[v].x_bd));
         check($sformatf("vec%0d.rdb_pend", v), 32'(b4_pend), 32'(vecs[v].x_bp));
         check($sformatf("vec%0d.addr_err", v), 32'(err4), 32'(0));
      end

      // Invalid index on the 3-entry instance: write to addr 3 pulses ADDR_ERR once.
      idle();
      wr_en = 1; wr_addr = 1; wr_data = 19'h0ABCD;
      step();
      idle();
      wr_en = 1; wr_addr = 3; wr_data = 19'h11111;
      step();
      check("inv.wr_err_pulse", 32'(err3), 32'(1));
      idle();
      step();
      check("inv.wr_err_clear", 32'(err3), 32'(0));
      rda_en = 1; rda_addr = 3; rdb_en = 1; rdb_addr = 1;
      step();
      check("inv.rd3_data", 32'(a3_data), 32'(0));
      check("inv.rd3_pend", 32'(a3_pend), 32'(0));
      check("inv.rd_err",   32'(err3),    32'(1));
      check("inv.r1_kept",  32'(b3_data), 32'(19'h0ABCD));
      // Several offenders in one cycle still give a single one-cycle pulse.
      idle();
      wr_en = 1; wr_addr = 3; sb_set = 1; sb_addr = 3; rda_en = 1; rda_addr = 3;
      step();
      check("inv.multi_err", 32'(err3), 32'(1));
      idle();
      step();
      check("inv.multi_clear", 32'(err3), 32'(0));
      for (int r = 0; r < 3; r++) begin
         rda_en = 1; rda_addr = 2'(r);
         step();
         check($sformatf("inv.r%0d_pend", r), 32'(a3_pend), 32'(0));
      end

      // Randomised traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         rst      = ($urandom_range(0, 63) == 0);
         wr_en    = 1'($urandom);
         wr_addr  = 2'($urandom);
         wr_data  = 19'($urandom);
         rda_en   = ($urandom_range(0, 3) != 0);
         rda_addr = 2'($urandom);
         rdb_en   = ($urandom_range(0, 3) != 0);
         rdb_addr = ($urandom_range(0, 3) == 0) ? rda_addr : 2'($urandom);
         sb_set   = 1'($urandom);
         sb_addr  = ($urandom_range(0, 3) == 0) ? wr_addr : 2'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
